// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares one 16-bit SDRAM request port between NUM_REQ requesters.
//   Only one transaction is in flight at a time. The winner's command is latched
//   at grant. sdr_req is held until sdr_rdy arrives. Completion is reported with
//   a one-cycle one-hot ack and, for reads, the returned data on rdata.
//
//   Build option ARB_ROUND_ROBIN_EN:
//     defined   -> round-robin arbitration
//     undefined -> fixed priority, where index 0 is the highest priority
//
//   Ports
//     sys_clk, reset         clock, asynchronous active-high reset
//     req/req_we             per-requester request level and write flag
//     req_addr/wdata/be      packed per-requester command fields (24/16/2 bits each)
//     ack                    one-hot completion pulse
//     rdata                  last read data
//     busy                   grant through ack cycle
//     grant_idx              current or last winner
//     sdr_addr/data/be/we    latched command to the SDRAM controller
//     sdr_req                request level to the SDRAM controller
//     sdr_rdy, sdr_q         completion pulse and read data from the SDRAM controller
module sdram_port_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*24-1:0] req_addr,
  input  logic [NUM_REQ*16-1:0] req_wdata,
  input  logic [NUM_REQ*2-1:0]  req_be,
  output logic [NUM_REQ-1:0]    ack,
  output logic [15:0]           rdata,
  output logic                  busy,
  output logic [2:0]            grant_idx,
  output logic [23:0]           sdr_addr,
  output logic [15:0]           sdr_data,
  output logic [1:0]            sdr_be,
  output logic                  sdr_we,
  output logic                  sdr_req,
  input  logic                  sdr_rdy,
  input  logic [15:0]           sdr_q
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic [2:0]          grant_q, grant_d;
  logic [23:0]         addr_q, addr_d;
  logic [15:0]         data_q, data_d;
  logic [1:0]          be_q, be_d;
  logic                we_q, we_d;
  logic                sreq_q, sreq_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0]          rr_q, rr_d;
`endif

  int unsigned         win;
  logic                found;
  logic [23:0]         sel_addr;
  logic [15:0]         sel_data;
  logic [1:0]          sel_be;
  logic                sel_we;

  // Winner selection and a mux of the winner's command fields.
  always_comb begin
    win   = 0;
    found = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    // Search order rr+1, rr+2, ... wrapping; the pointer itself comes last.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (i == (32'(rr_q) + k) % NUM_REQ)) begin
          win   = i;
          found = 1'b1;
        end
      end
    end
`else
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        win   = i;
        found = 1'b1;
      end
    end
`endif
    sel_addr = '0;
    sel_data = '0;
    sel_be   = '0;
    sel_we   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (i == win) begin
        sel_addr = req_addr[24*i +: 24];
        sel_data = req_wdata[16*i +: 16];
        sel_be   = req_be[2*i +: 2];
        sel_we   = req_we[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    we_d    = we_q;
    sreq_d  = sreq_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          addr_d  = sel_addr;
          data_d  = sel_data;
          be_d    = sel_be;
          we_d    = sel_we;
          sreq_d  = 1'b1;
          busy_d  = 1'b1;
          grant_d = 3'(win);
`ifdef ARB_ROUND_ROBIN_EN
          rr_d    = 3'(win);
`endif
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (sdr_rdy) begin
          sreq_d = 1'b0;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            ack_d[i] = (32'(grant_q) == i);
          end
          if (!we_q) rdata_d = sdr_q;
          state_d = DONE;
        end
      end
      DONE: begin
        // req is not looked at here, so a level still held from the
        // acked requester cannot cause a second grant.
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      sreq_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= 3'(NUM_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      we_q    <= we_d;
      sreq_q  <= sreq_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign grant_idx = grant_q;
  assign sdr_addr  = addr_q;
  assign sdr_data  = data_q;
  assign sdr_be    = be_q;
  assign sdr_we    = we_q;
  assign sdr_req   = sreq_q;

endmodule
